lcd_sequencer: RTL and testbench
================================

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter EN_PULSE_CYC, default 25, SHALL set the lcd_en high time in clk cycles (500 ns at 50 MHz).
REQ-002 Parameter CMD_WAIT_CYC, default 2500, SHALL set the post-strobe wait for ordinary commands and data writes.
REQ-003 Parameter CLR_WAIT_CYC, default 82000, SHALL set the post-strobe wait for opcodes 0x01 and 0x02.
REQ-004 Parameter PWRUP_WAIT_CYC, default 750000, SHALL set the delay from reset release to the first init command.
REQ-005 Ports SHALL be:
 - clk  in  1  single clock; all state changes on the rising edge.
 - reset  in  1  asynchronous, active-low reset.
 - clk_en  in  1  custom-instruction clock enable.
 - start  in  1  one-cycle request strobe.
 - dataa  in  32  opcode in [7:0]; [31:8] ignored.
 - datab  in  32  character in [7:0] for opcode 0x25.
 - done  out  1  one-cycle completion pulse.
 - result  out  32  completion status.
 - lcd_data  out  8  LCD data bus.
 - lcd_rs, lcd_rw, lcd_en, lcd_backlight  out  1 each  LCD control pins.

Function
REQ-006 Supported opcodes SHALL be 0x01, 0x02, 0x08, 0x0C, 0x0E, 0x10, 0x14, 0x20, 0x28, 0x30 and 0x38, each sent as a command byte with rs=0, plus 0x25, which sends datab[7:0] with rs=1.
REQ-007 lcd_rw SHALL always be 0.
REQ-008 The FSM states SHALL be PWRUP_WAIT, INIT_ISSUE, IDLE, SETUP, EN_HIGH, POST_WAIT and DONE.
REQ-009 Transfer timing:
 - SETUP: 1 cycle; lcd_data and lcd_rs valid, lcd_en=0.
 - EN_HIGH: EN_PULSE_CYC cycles with lcd_en=1.
 - POST_WAIT: CMD_WAIT_CYC or CLR_WAIT_CYC cycles with lcd_en=0.
 - DONE: 1 cycle with done=1.
 - Latency from start to done SHALL be 2+EN_PULSE_CYC+wait cycles.
REQ-010 lcd_data and lcd_rs SHALL stay stable from SETUP through the end of POST_WAIT.
REQ-011 result SHALL be valid while done=1:
 - accepted opcode: result[11:0] = {lcd_backlight, 1'b1, rs, 1'b0, byte}, other bits 0.
 - unsupported opcode: no bus activity, done in the cycle after start, result=32'h8000_0000.
REQ-012 When clk_en=0, state, counters and outputs SHALL freeze, start SHALL be ignored, and a pending done SHALL be held until clk_en=1.
REQ-013 A start seen in IDLE SHALL be accepted, and dataa/datab SHALL be captured in that cycle.
REQ-014 A start seen during PWRUP_WAIT or INIT_ISSUE SHALL be latched into a single pending slot and executed immediately after init completes.
REQ-015 A start seen while a transfer is in progress, or while the pending slot is full, SHALL be ignored with no done.
REQ-016 Init SHALL send 0x38, 0x0C, 0x01, 0x06 in order, each using the REQ-009 timing with no done pulses.
REQ-017 lcd_backlight SHALL become 1 on the cycle IDLE is first entered and SHALL then stay 1.
REQ-018 Delay counters SHALL be wide enough for the largest parameter value and SHALL NOT wrap.
REQ-019 A parameter value of 0 SHALL be treated as 1.

Reset
REQ-020 While reset=0, outputs SHALL be driven asynchronously to:
 - done=0, result=0
 - lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_backlight=0
 - pending slot cleared.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer with no done; after release, the FSM SHALL start in PWRUP_WAIT.

Configuration
REQ-022 With LCD_SEQ_INIT_EN defined:
 - power-up wait and init sequence are present; reset release enters PWRUP_WAIT.
REQ-023 Without LCD_SEQ_INIT_EN:
 - no power-up wait or init logic.
 - reset release enters IDLE directly; lcd_backlight=1 from the first cycle after release.
 - REQ-014 does not apply.

Structure
REQ-024 Package lcd_pkg SHALL hold:
 - the opcode constants
 - the result bit positions (BACKLIGHT=11, EN=10, RS=9, RW=8)
 - the FSM state enum
 - the init command table.
REQ-025 Sub-module lcd_delay_counter SHALL provide a loadable down-counter with a zero flag, shared by all timed states.

Verification (sim parameters EN_PULSE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, PWRUP_WAIT_CYC=10, macro defined)
REQ-026 Reset release -> exactly four lcd_en pulses carrying 0x38, 0x0C, 0x01, 0x06, the first lcd_en rise 12 cycles after release, then lcd_backlight=1.
REQ-027 In IDLE, start with dataa=0x25, datab=0x41 -> lcd_data=0x41, lcd_rs=1, lcd_en high for 2 cycles, done at start+8, result=32'h0000_0E41.
REQ-028 In IDLE, start with dataa=0x01 -> done at start+12, result=32'h0000_0C01.
REQ-029 In IDLE, start with dataa=0x55 -> lcd_en stays 0, done at start+1, result=32'h8000_0000.
REQ-030 Start with dataa=0x0E during PWRUP_WAIT -> executes right after init, exactly one done; a second start mid-transfer produces no done.
REQ-031 reset=0 while lcd_en=1 -> lcd_en=0 in the same cycle, no done; clk_en=0 for 5 cycles mid-transfer -> done delayed by exactly 5 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the LCD command sequencer.
package lcd_pkg;

  localparam logic [7:0] OP_CLEAR      = 8'h01;
  localparam logic [7:0] OP_HOME       = 8'h02;
  localparam logic [7:0] OP_ENTRY      = 8'h06;
  localparam logic [7:0] OP_DISP_OFF   = 8'h08;
  localparam logic [7:0] OP_DISP_ON    = 8'h0C;
  localparam logic [7:0] OP_CURSOR_ON  = 8'h0E;
  localparam logic [7:0] OP_SHIFT_L    = 8'h10;
  localparam logic [7:0] OP_SHIFT_R    = 8'h14;
  localparam logic [7:0] OP_FUNC_4B1L  = 8'h20;
  localparam logic [7:0] OP_FUNC_4B2L  = 8'h28;
  localparam logic [7:0] OP_FUNC_8B1L  = 8'h30;
  localparam logic [7:0] OP_FUNC_8B2L  = 8'h38;
  localparam logic [7:0] OP_WRITE      = 8'h25;

  localparam int RES_BACKLIGHT = 11;
  localparam int RES_EN        = 10;
  localparam int RES_RS        = 9;
  localparam int RES_RW        = 8;
  localparam logic [31:0] RES_UNSUPPORTED = 32'h8000_0000;

  typedef enum logic [2:0] {
    PWRUP_WAIT,
    INIT_ISSUE,
    IDLE,
    SETUP,
    EN_HIGH,
    POST_WAIT,
    DONE
  } lcd_state_t;

  // Entry 0 is sent first.
  localparam int INIT_LEN = 4;
  localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE =
    {OP_ENTRY, OP_CLEAR, OP_DISP_ON, OP_FUNC_8B2L};

  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counters hold N-1 down to 0, so clog2(N) bits cover the largest wait.
  function automatic int cnt_width(input int maxv);
    return (maxv <= 2) ? 1 : $clog2(maxv);
  endfunction

  function automatic logic is_command(input logic [7:0] op);
    logic ok;
    case (op)
      OP_CLEAR, OP_HOME, OP_DISP_OFF, OP_DISP_ON, OP_CURSOR_ON, OP_SHIFT_L,
      OP_SHIFT_R, OP_FUNC_4B1L, OP_FUNC_4B2L, OP_FUNC_8B1L, OP_FUNC_8B2L,
      OP_WRITE: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_long_wait(input logic [7:0] op);
    return (op == OP_CLEAR) || (op == OP_HOME);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module lcd_delay_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= RESET_VAL;
    end else if (en) begin
      if (load) begin
        count_reg <= load_val;
      end else if (count_reg != '0) begin
        count_reg <= count_reg - WIDTH'(1);
      end
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// Custom-instruction LCD command sequencer (HD44780-style 8-bit bus).
// Define LCD_SEQ_INIT_EN to include the power-up wait and init sequence.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int EN_PULSE_CYC   = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLR_WAIT_CYC   = 82000,
  parameter int PWRUP_WAIT_CYC = 750000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_backlight
);

  localparam int EN_C    = clamp1(EN_PULSE_CYC);
  localparam int CMD_C   = clamp1(CMD_WAIT_CYC);
  localparam int CLR_C   = clamp1(CLR_WAIT_CYC);
  localparam int PWRUP_C = clamp1(PWRUP_WAIT_CYC);
  localparam int MAX_C   = max2(max2(EN_C, CMD_C), max2(CLR_C, PWRUP_C));
  localparam int CW      = cnt_width(MAX_C);

  localparam logic [CW-1:0] EN_LD  = CW'(EN_C - 1);
  localparam logic [CW-1:0] CMD_LD = CW'(CMD_C - 1);
  localparam logic [CW-1:0] CLR_LD = CW'(CLR_C - 1);

`ifdef LCD_SEQ_INIT_EN
  localparam lcd_state_t    RESET_STATE = PWRUP_WAIT;
  localparam logic [CW-1:0] CNT_RESET   = CW'(PWRUP_C - 1);
  localparam logic [1:0]    INIT_LAST   = 2'(INIT_LEN - 1);
`else
  localparam lcd_state_t    RESET_STATE = IDLE;
  localparam logic [CW-1:0] CNT_RESET   = '0;
`endif

  lcd_state_t    state_reg, state_next;
  logic          cnt_load, cnt_zero;
  logic [CW-1:0] cnt_load_val;
  logic          accept_cmd, accept_bad, load_init;
  logic [7:0]    data_reg;
  logic          rs_reg, err_reg, backlight_reg;
  logic          req_valid;
  logic [7:0]    req_op, req_chr;
  logic          unused_ok;

  assign unused_ok = ^{dataa[31:8], datab[31:8]};

`ifdef LCD_SEQ_INIT_EN
  logic       init_phase;
  logic [1:0] init_idx_reg;
  logic       pend_valid_reg;
  logic [7:0] pend_op_reg, pend_chr_reg;

  // Backlight turns on exactly when init finishes, so it doubles as the init flag.
  assign init_phase = !backlight_reg;
  assign req_valid  = pend_valid_reg || start;
  assign req_op     = pend_valid_reg ? pend_op_reg  : dataa[7:0];
  assign req_chr    = pend_valid_reg ? pend_chr_reg : datab[7:0];

  // Requests arriving anywhere in the init phase are parked and run from IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_idx_reg   <= '0;
      pend_valid_reg <= 1'b0;
      pend_op_reg    <= '0;
      pend_chr_reg   <= '0;
    end else if (clk_en) begin
      if (state_reg == POST_WAIT && cnt_zero && init_phase) begin
        init_idx_reg <= init_idx_reg + 2'd1;
      end
      if (init_phase && start && !pend_valid_reg) begin
        pend_valid_reg <= 1'b1;
        pend_op_reg    <= dataa[7:0];
        pend_chr_reg   <= datab[7:0];
      end else if (state_reg == IDLE) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end
`else
  assign req_valid = start;
  assign req_op    = dataa[7:0];
  assign req_chr   = datab[7:0];
`endif

  lcd_delay_counter #(
    .WIDTH     (CW),
    .RESET_VAL (CNT_RESET)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .en       (clk_en),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RESET_STATE;
    end else if (clk_en) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    accept_cmd   = 1'b0;
    accept_bad   = 1'b0;
    load_init    = 1'b0;
    case (state_reg)
`ifdef LCD_SEQ_INIT_EN
      PWRUP_WAIT: if (cnt_zero) state_next = INIT_ISSUE;
      INIT_ISSUE: begin
        load_init  = 1'b1;
        state_next = SETUP;
      end
`endif
      IDLE: begin
        if (req_valid) begin
          if (is_command(req_op)) begin
            accept_cmd = 1'b1;
            state_next = SETUP;
          end else begin
            accept_bad = 1'b1;
            state_next = DONE;
          end
        end
      end
      SETUP: begin
        cnt_load     = 1'b1;
        cnt_load_val = EN_LD;
        state_next   = EN_HIGH;
      end
      EN_HIGH: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = (!rs_reg && is_long_wait(data_reg)) ? CLR_LD : CMD_LD;
          state_next   = POST_WAIT;
        end
      end
      POST_WAIT: begin
        if (cnt_zero) begin
`ifdef LCD_SEQ_INIT_EN
          if (init_phase) begin
            state_next = (init_idx_reg == INIT_LAST) ? IDLE : INIT_ISSUE;
          end else begin
            state_next = DONE;
          end
`else
          state_next = DONE;
`endif
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = RESET_STATE;
    endcase
  end

  // Bus byte and rs are captured once and held through POST_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg      <= '0;
      rs_reg        <= 1'b0;
      err_reg       <= 1'b0;
      backlight_reg <= 1'b0;
    end else if (clk_en) begin
      if (accept_cmd) begin
        data_reg <= (req_op == OP_WRITE) ? req_chr : req_op;
        rs_reg   <= (req_op == OP_WRITE);
        err_reg  <= 1'b0;
      end else if (accept_bad) begin
        err_reg <= 1'b1;
      end
`ifdef LCD_SEQ_INIT_EN
      if (load_init) begin
        data_reg <= INIT_TABLE[init_idx_reg];
        rs_reg   <= 1'b0;
      end
`endif
      if (state_next == IDLE) begin
        backlight_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    lcd_en = (state_reg == EN_HIGH);
    done   = (state_reg == DONE);
    result = '0;
    if (state_reg == DONE) begin
      if (err_reg) begin
        result = RES_UNSUPPORTED;
      end else begin
        result[7:0]           = data_reg;
        result[RES_RW]        = 1'b0;
        result[RES_RS]        = rs_reg;
        result[RES_EN]        = 1'b1;
        result[RES_BACKLIGHT] = backlight_reg;
      end
    end
  end

  assign lcd_data      = data_reg;
  assign lcd_rs        = rs_reg;
  assign lcd_rw        = 1'b0;
  assign lcd_backlight = backlight_reg;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: stimulus pushes expected completions and
// bus pulses, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_lcd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        done;
  logic [31:0] result;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_backlight;

  always #5 clk = ~clk;

  lcd_sequencer #(
    .EN_PULSE_CYC   (2),
    .CMD_WAIT_CYC   (4),
    .CLR_WAIT_CYC   (8),
    .PWRUP_WAIT_CYC (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .start         (start),
    .dataa         (dataa),
    .datab         (datab),
    .done          (done),
    .result        (result),
    .lcd_data      (lcd_data),
    .lcd_rs        (lcd_rs),
    .lcd_rw        (lcd_rw),
    .lcd_en        (lcd_en),
    .lcd_backlight (lcd_backlight)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    int          cyc;
  } done_exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
  } bus_exp_t;

  done_exp_t done_q[$];
  bus_exp_t  bus_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_done(input string name, input logic [31:0] res, input int c);
    done_exp_t e;
    e.name = name;
    e.res  = res;
    e.cyc  = c;
    done_q.push_back(e);
  endtask

  task automatic push_bus(input logic rs, input logic [7:0] data, input int rise);
    bus_exp_t b;
    b.rs   = rs;
    b.data = data;
    b.rise = rise;
    bus_q.push_back(b);
  endtask

  // Init pulses rise 12/20/28/40 cycles after release (0x01 uses the long wait).
  task automatic push_init(input int r);
    push_bus(1'b0, 8'h38, r + 12);
    push_bus(1'b0, 8'h0C, r + 20);
    push_bus(1'b0, 8'h01, r + 28);
    push_bus(1'b0, 8'h06, r + 40);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; start is high for the current cycle only.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] res, output int sc);
    sc = cyc;
    start = 1'b1;
    dataa = a;
    datab = b;
    if (lat >= 0) begin
      push_done(name, res, sc + lat);
      if (!res[31]) push_bus(res[9], res[7:0], sc + 2);
    end
    $display("issue %s dataa=%08h datab=%08h cycle=%0d expect_lat=%0d", name, a, b, sc, lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    dataa = '0;
    datab = '0;
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] res);
    int sc;
    issue(name, a, b, lat, res, sc);
    wait_cyc(sc + lat + 2);
  endtask

  // Monitor: completions and lcd_en pulses.
  logic       en_prev = 1'b0;
  int         rise_cyc = 0;
  int         en_len = 0;
  logic [7:0] rise_data = '0;
  logic       rise_rs = 1'b0;
  done_exp_t  de;
  bus_exp_t   be;

  always @(negedge clk) begin
    if (!reset) begin
      en_prev = 1'b0;
    end else begin
      if (done && clk_en) begin
        if (done_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got result %0h at cycle %0d, required no done", result, cyc);
        end else begin
          de = done_q.pop_front();
          chk({de.name, "_cycle"}, cyc, de.cyc);
          chk({de.name, "_result"}, result, de.res);
          $display("done %s result=%08h cycle=%0d", de.name, result, cyc);
        end
      end
      if (lcd_en && !en_prev) begin
        rise_cyc  = cyc;
        rise_data = lcd_data;
        rise_rs   = lcd_rs;
        en_len    = 0;
      end
      if (lcd_en && clk_en) en_len++;
      if (!lcd_en && en_prev) begin
        if (bus_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: got data %0h at cycle %0d, required no pulse", rise_data, rise_cyc);
        end else begin
          be = bus_q.pop_front();
          chk("bus_data", rise_data, be.data);
          chk("bus_rs", rise_rs, be.rs);
          chk("bus_len", en_len, 2);
          chk("bus_data_hold", lcd_data, be.data);
          chk("bus_rs_hold", lcd_rs, be.rs);
          chk("bus_rw", lcd_rw, 1'b0);
          if (be.rise >= 0) chk("bus_rise", rise_cyc, be.rise);
          $display("pulse data=%02h rs=%0b rise=%0d len=%0d", rise_data, rise_rs, rise_cyc, en_len);
        end
      end
      en_prev = lcd_en;
    end
  end

  initial begin
    int r;
    int sc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_en", lcd_en, 1'b0);
    chk("rst_backlight", lcd_backlight, 1'b0);

    reset = 1'b1;
    r = cyc;
`ifdef LCD_SEQ_INIT_EN
    push_init(r);
    wait_cyc(r + 3);
    issue("pend_0E", 32'h0E, 32'h0, -1, 32'h0, sc);
    push_done("pend_0E", 32'h0000_0C0E, r + 54);
    push_bus(1'b0, 8'h0E, r + 48);
    wait_cyc(r + 5);
    issue("pend_full_38", 32'h38, 32'h0, -1, 32'h0, sc);
    wait_cyc(r + 45);
    chk("bl_before_idle", lcd_backlight, 1'b0);
    wait_cyc(r + 46);
    chk("bl_at_idle", lcd_backlight, 1'b1);
    wait_cyc(r + 50);
    issue("busy_08", 32'h08, 32'h0, -1, 32'h0, sc);
    wait_cyc(r + 57);
`else
    wait_cyc(r + 1);
    chk("bl_first_cycle", lcd_backlight, 1'b1);
    wait_cyc(r + 2);
`endif

    run("wr_41",      32'h25,        32'h41,        8,  32'h0000_0E41);
    run("clr_01",     32'h01,        32'h0,         12, 32'h0000_0C01);
    run("bad_55",     32'h55,        32'h0,         1,  32'h8000_0000);
    run("home_02",    32'h02,        32'h0,         12, 32'h0000_0C02);
    run("fn_38",      32'h38,        32'h0,         8,  32'h0000_0C38);
    run("hibits_0C",  32'hFFFF_FF0C, 32'hFFFF_FFFF, 8,  32'h0000_0C0C);
    run("bad_06",     32'h06,        32'h0,         1,  32'h8000_0000);
    run("wr_7E_hi",   32'hABCD_0025, 32'h1234_567E, 8,  32'h0000_0E7E);

    issue("pause_10", 32'h10, 32'h0, 13, 32'h0000_0C10, sc);
    wait_cyc(sc + 5);
    clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clk_en = 1'b1;
    wait_cyc(sc + 15);

    issue("hold_55", 32'h55, 32'h0, 4, 32'h8000_0000, sc);
    clk_en = 1'b0;
    @(posedge clk);
    #1;
    chk("done_held", done, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clk_en = 1'b1;
    wait_cyc(sc + 6);

    clk_en = 1'b0;
    issue("frozen_55", 32'h55, 32'h0, -1, 32'h0, sc);
    @(posedge clk);
    #1;
    clk_en = 1'b1;
    wait_cyc(sc + 5);

    issue("abort_28", 32'h28, 32'h0, -1, 32'h0, sc);
    for (int i = 0; i < 20 && !lcd_en; i++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_en_seen", lcd_en, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_en_low", lcd_en, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_backlight", lcd_backlight, 1'b0);
    chk("abort_data", lcd_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    r = cyc;
`ifdef LCD_SEQ_INIT_EN
    push_init(r);
    wait_cyc(r + 45);
    chk("bl_reinit_before", lcd_backlight, 1'b0);
    wait_cyc(r + 46);
    chk("bl_reinit", lcd_backlight, 1'b1);
    wait_cyc(r + 47);
`else
    wait_cyc(r + 1);
    chk("bl_reinit", lcd_backlight, 1'b1);
    wait_cyc(r + 2);
`endif
    run("post_rst_14", 32'h14, 32'h0, 8, 32'h0000_0C14);

    chk("done_q_empty", done_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
